// File: rtl/mmcm_reset_sequencer.sv
// -----------------------------------------------------------------------------
// mmcm_reset_sequencer
//
// Control-side companion of the system clock generator MMCM. Drives the MMCM
// reset pin, synchronizes and filters its LOCKED output, and releases a set of
// downstream domain resets one after another once lock has been stable for
// long enough. It recovers from lock loss and from lock timeout. Runs on the
// free-running reference clock that also feeds the MMCM input.
//
// Ports:
//   clk_in        in   free-running reference clock (same as MMCM CLKIN1)
//   reset         in   synchronous, active-high block reset
//   locked_in     in   MMCM LOCKED, asynchronous to clk_in
//   force_reset   in   level request to restart the sequence (clk_in domain)
//   mmcm_reset    out  MMCM RST, active high
//   rst_out       out  NUM_RST downstream resets, active high, bit i released i-th
//   ready         out  all rst_out released and lock good
//   relock_count  out  number of lock-loss restarts, saturating at 255
//   timeout_err   out  sticky flag, at least one lock timeout occurred
//
// Build option:
//   MMCM_SEQ_AUTO_RELOCK_EN  defined   : lock loss in S_RELEASE/S_RUN restarts
//                                        the sequence automatically.
//                            undefined : lock loss parks in S_FAULT (MMCM held
//                                        in reset) until force_reset or reset.
//
// TCQ is kept for compatibility with existing instantiations; registered
// assignments in this model carry no clock-to-out delay.
// -----------------------------------------------------------------------------
module mmcm_reset_sequencer #(
  parameter int TCQ                 = 1,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_FILTER_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int NUM_RST             = 3,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               locked_in,
  input  logic               force_reset,
  output logic               mmcm_reset,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic [7:0]         relock_count,
  output logic               timeout_err
);

  localparam int PULSE_W  = $clog2(RST_PULSE_CYCLES) + 1;
  localparam int FILT_W   = $clog2(LOCK_FILTER_CYCLES) + 1;
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam int STAG_MAX = STAGGER_CYCLES * NUM_RST;
  localparam int STAG_W   = $clog2(STAG_MAX) + 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  // The locked_s sample that moves S_WAIT_LOCK to S_FILTER is the first of the
  // consecutive locked cycles, so S_FILTER needs LOCK_FILTER_CYCLES-1 more.
  localparam logic [FILT_W-1:0]  FILT_LAST  =
    FILT_W'((LOCK_FILTER_CYCLES >= 2) ? (LOCK_FILTER_CYCLES - 2) : 0);
  localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [STAG_W-1:0]  STAG_LAST  = STAG_W'(STAG_MAX);

  if (TCQ < 0 || RST_PULSE_CYCLES < 1 || LOCK_FILTER_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 2 || NUM_RST < 1 || NUM_RST > 8 ||
      STAGGER_CYCLES < 1) begin : g_param_check
    $error("mmcm_reset_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

`ifdef MMCM_SEQ_AUTO_RELOCK_EN
  localparam state_t LOSS_STATE = S_RST;
`else
  localparam state_t LOSS_STATE = S_FAULT;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  logic                lock_meta_p0;
  logic                locked_s;

  state_t              state, state_nx;
  logic [PULSE_W-1:0]  pulse_cnt, pulse_nx;
  logic [FILT_W-1:0]   filt_cnt, filt_nx;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nx, tmo_inc;
  logic [STAG_W-1:0]   stag_cnt, stag_nx;
  logic [7:0]          relock_nx;
  logic                tmo_err_nx;
  logic                mmcm_reset_nx;
  logic [NUM_RST-1:0]  rst_out_nx;
  logic                ready_nx;

  // Stage p0 -> locked_s: two-flop synchronizer for the asynchronous LOCKED
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lock_meta_p0 <= 1'b0;
      locked_s     <= 1'b0;
    end else begin
      lock_meta_p0 <= locked_in;
      locked_s     <= lock_meta_p0;
    end
  end

  always_comb begin
    state_nx   = state;
    pulse_nx   = pulse_cnt;
    filt_nx    = filt_cnt;
    tmo_nx     = tmo_cnt;
    stag_nx    = stag_cnt;
    relock_nx  = relock_count;
    tmo_err_nx = timeout_err;
    tmo_inc    = tmo_cnt + 1'b1;

    if (force_reset) begin
      // Holding the pulse counter at zero stretches mmcm_reset over the whole
      // force level; lock loss and timeout are ignored in this cycle.
      state_nx = S_RST;
      pulse_nx = '0;
      filt_nx  = '0;
      tmo_nx   = '0;
      stag_nx  = '0;
    end else begin
      case (state)
        S_RST: begin
          filt_nx = '0;
          tmo_nx  = '0;
          stag_nx = '0;
          if (pulse_cnt == PULSE_LAST) begin
            state_nx = S_WAIT_LOCK;
            pulse_nx = '0;
          end else begin
            pulse_nx = pulse_cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          tmo_nx = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            state_nx   = S_RST;
            tmo_err_nx = 1'b1;
            tmo_nx     = '0;
            pulse_nx   = '0;
          end else if (locked_s) begin
            filt_nx = '0;
            stag_nx = '0;
            if (LOCK_FILTER_CYCLES < 2) state_nx = S_RELEASE;
            else                        state_nx = S_FILTER;
          end
        end

        S_FILTER: begin
          // The timeout keeps running across filter restarts so a chattering
          // LOCKED cannot stall the sequence forever.
          tmo_nx = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            state_nx   = S_RST;
            tmo_err_nx = 1'b1;
            tmo_nx     = '0;
            pulse_nx   = '0;
            filt_nx    = '0;
          end else if (!locked_s) begin
            state_nx = S_WAIT_LOCK;
            filt_nx  = '0;
          end else if (filt_cnt == FILT_LAST) begin
            state_nx = S_RELEASE;
            filt_nx  = '0;
            stag_nx  = '0;
          end else begin
            filt_nx = filt_cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if (!locked_s) begin
            state_nx  = LOSS_STATE;
            relock_nx = sat_inc8(relock_count);
            pulse_nx  = '0;
            stag_nx   = '0;
          end else if (stag_cnt == STAG_LAST) begin
            state_nx = S_RUN;
            stag_nx  = '0;
          end else begin
            stag_nx = stag_cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state_nx  = LOSS_STATE;
            relock_nx = sat_inc8(relock_count);
            pulse_nx  = '0;
          end
        end

        S_FAULT: begin
          pulse_nx = '0;
        end

        default: begin
          state_nx = S_RST;
          pulse_nx = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so that they leave the register
    // in the same cycle as the state they belong to.
    mmcm_reset_nx = (state_nx == S_RST) || (state_nx == S_FAULT);
    ready_nx      = (state_nx == S_RUN);
    rst_out_nx    = '1;
    if (state_nx == S_RUN) begin
      rst_out_nx = '0;
    end else if (state_nx == S_RELEASE) begin
      for (int i = 0; i < NUM_RST; i++) begin
        rst_out_nx[i] = (stag_nx < STAG_W'(STAGGER_CYCLES * (i + 1)));
      end
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= S_RST;
      pulse_cnt    <= '0;
      filt_cnt     <= '0;
      tmo_cnt      <= '0;
      stag_cnt     <= '0;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
      mmcm_reset   <= 1'b1;
      rst_out      <= '1;
      ready        <= 1'b0;
    end else begin
      state        <= state_nx;
      pulse_cnt    <= pulse_nx;
      filt_cnt     <= filt_nx;
      tmo_cnt      <= tmo_nx;
      stag_cnt     <= stag_nx;
      relock_count <= relock_nx;
      timeout_err  <= tmo_err_nx;
      mmcm_reset   <= mmcm_reset_nx;
      rst_out      <= rst_out_nx;
      ready        <= ready_nx;
    end
  end

endmodule
